// File: rtl/im_loader.sv
// im_loader: assembles a UART byte stream (16-bit LE word count, then LE
// 32-bit words) into instruction-memory writes, then starts the processor
// and waits for it to report completion.
module im_loader #(
    parameter int IM_MEM_DEPTH = 512,
    parameter int DATA_WIDTH   = 32,
    localparam int AW          = $clog2(IM_MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  im_wr_en,
    output logic [AW-1:0]         im_wr_addr,
    output logic [DATA_WIDTH-1:0] im_wr_data,
    output logic                  startProcess,
    input  logic                  endProcess,
    output logic                  busy,
    output logic                  run_done,
    output logic                  error
);

    typedef enum logic [2:0] {
        S_IDLE, S_CNT_HI, S_LOAD, S_START, S_RUN, S_ERR
    } state_t;

    state_t                state_q, state_d;
    logic [7:0]            cnt_lo_q, cnt_lo_d;
    logic [AW:0]           n_q, n_d;          // AW+1 bits so N == depth fits
    logic [AW:0]           wcnt_q, wcnt_d;
    logic [1:0]            idx_q, idx_d;
    logic [DATA_WIDTH-9:0] asm_q, asm_d;      // first three bytes of a word
    logic                  wr_en_q, wr_en_d;
    logic [AW-1:0]         wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  start_q, start_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic                  error_q, error_d;
    logic [15:0]           n_full;

    // Next-state, header check, word assembly and write/handshake requests
    always_comb begin
        state_d   = state_q;
        cnt_lo_d  = cnt_lo_q;
        n_d       = n_q;
        wcnt_d    = wcnt_q;
        idx_d     = idx_q;
        asm_d     = asm_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        start_d   = 1'b0;
        done_d    = 1'b0;
        n_full    = {rx_data, cnt_lo_q};
        case (state_q)
            S_IDLE: begin
                if (rx_valid) begin
                    cnt_lo_d = rx_data;
                    state_d  = S_CNT_HI;
                end
            end
            S_CNT_HI: begin
                if (rx_valid) begin
                    if (n_full == 16'd0 || n_full > 16'(IM_MEM_DEPTH)) begin
                        state_d = S_ERR;
                    end else begin
                        n_d     = n_full[AW:0];
                        idx_d   = 2'd0;
                        wcnt_d  = '0;
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (rx_valid) begin
                    idx_d = idx_q + 2'd1;
                    // Right shift so the first byte ends up in the low lane
                    asm_d = {rx_data, asm_q[DATA_WIDTH-9:8]};
                    if (idx_q == 2'd3) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = wcnt_q[AW-1:0];
                        wr_data_d = {rx_data, asm_q};
                        wcnt_d    = wcnt_q + (AW+1)'(1);
                        if (wcnt_q == n_q - (AW+1)'(1))
                            state_d = S_START;
                    end
                end
            end
            S_START: begin
                start_d = 1'b1;
                state_d = S_RUN;
            end
            S_RUN: begin
                // endProcess in the same cycle as startProcess is stale
                if (endProcess && !start_q) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase
        busy_d  = (state_d != S_IDLE) && (state_d != S_ERR);
        error_d = (state_d == S_ERR);
    end

    // FSM, counters, assembly register and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_lo_q <= '0;
            n_q      <= '0;
            wcnt_q   <= '0;
            idx_q    <= '0;
            asm_q    <= '0;
            start_q  <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_lo_q <= cnt_lo_d;
            n_q      <= n_d;
            wcnt_q   <= wcnt_d;
            idx_q    <= idx_d;
            asm_q    <= asm_d;
            start_q  <= start_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            error_q  <= error_d;
        end
    end

    // IM write stage, decoupled from the FSM; address/data hold when idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign im_wr_en     = wr_en_q;
    assign im_wr_addr   = wr_addr_q;
    assign im_wr_data   = wr_data_q;
    assign startProcess = start_q;
    assign run_done     = done_q;
    assign busy         = busy_q;
    assign error        = error_q;

endmodule

// File: tb/tb_im_loader.sv
// Randomized bench for im_loader: a monitor logs every write/start/done with
// its cycle number, and each test compares the log against what the stream
// format and latency rules predict.
module tb_im_loader;
    localparam int DEPTH = 512;
    localparam int AW    = 9;

    logic          clk = 1'b0, rst = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0, endProcess = 1'b0;
    logic          im_wr_en, startProcess, busy, run_done, error;
    logic [AW-1:0] im_wr_addr;
    logic [31:0]   im_wr_data;

    int tests = 0, fails = 0, cyc = 0, last_cyc = 0;
    logic [AW-1:0] w_addr[$];
    logic [31:0]   w_data[$];
    int            w_cyc[$], s_cyc[$], d_cyc[$];
    logic [31:0]   words[$];
    int            e_cyc[$];

    im_loader #(.IM_MEM_DEPTH(DEPTH), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .im_wr_en(im_wr_en), .im_wr_addr(im_wr_addr), .im_wr_data(im_wr_data),
        .startProcess(startProcess), .endProcess(endProcess), .busy(busy),
        .run_done(run_done), .error(error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // cycle-stamped log of DUT events, sampled away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            if (im_wr_en) begin
                w_addr.push_back(im_wr_addr);
                w_data.push_back(im_wr_data);
                w_cyc.push_back(cyc);
            end
            if (startProcess) s_cyc.push_back(cyc);
            if (run_done)     d_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_log();
        w_addr.delete(); w_data.delete(); w_cyc.delete();
        s_cyc.delete(); d_cyc.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b; rx_valid = 1'b1; tick(); rx_valid = 1'b0;
    endtask

    task automatic release_reset();
        @(posedge clk); #1 rst = 1'b0;
    endtask

    // Stream = count LE, then each word LE. A write is expected in the cycle
    // right after the edge that samples the 4th byte of each word.
    task automatic send_stream(input logic [15:0] n, input int gap_max, input int nbytes);
        logic [7:0]  b[$];
        logic [31:0] w;
        int          lim;
        bit          hv;
        hv = (n != 0) && (n <= DEPTH);
        b.push_back(n[7:0]); b.push_back(n[15:8]);
        foreach (words[k]) begin
            w = words[k];
            for (int j = 0; j < 4; j++) b.push_back(w[8*j +: 8]);
        end
        lim = (nbytes < 0) ? b.size() : nbytes;
        e_cyc.delete();
        for (int i = 0; i < lim; i++) begin
            if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) tick();
            send_byte(b[i]);
            if (hv && i >= 2 && ((i - 2) % 4) == 3) e_cyc.push_back(cyc);
        end
        last_cyc = cyc;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #3;
        tests += 7;
        if (im_wr_en !== 1'b0)       begin fails++; $display("FAIL reset_wr_en got %b exp 0", im_wr_en); end
        if (im_wr_addr !== '0)       begin fails++; $display("FAIL reset_wr_addr got %h exp 0", im_wr_addr); end
        if (im_wr_data !== 32'h0)    begin fails++; $display("FAIL reset_wr_data got %h exp 0", im_wr_data); end
        if (startProcess !== 1'b0)   begin fails++; $display("FAIL reset_start got %b exp 0", startProcess); end
        if (busy !== 1'b0)           begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
        if (run_done !== 1'b0)       begin fails++; $display("FAIL reset_run_done got %b exp 0", run_done); end
        if (error !== 1'b0)          begin fails++; $display("FAIL reset_error got %b exp 0", error); end
        release_reset();
    endtask

    // N=2 back-to-back, coincident endProcess ignored, later end accepted,
    // endProcess held into IDLE harmless, then a new header is accepted.
    task automatic test_basic();
        int e;
        clear_log();
        words = {32'h0000_0013, 32'h0010_0093};
        send_stream(16'd2, 0, -1);
        tick();                                // startProcess cycle
        endProcess = 1'b1; tick(); endProcess = 1'b0;
        repeat (3) tick();
        tests++;
        if (w_addr.size() != 2) begin fails++; $display("FAIL basic_wr_count got %0d exp 2", w_addr.size()); end
        for (int k = 0; k < 2 && k < w_addr.size(); k++) begin
            tests++;
            if (w_addr[k] !== AW'(k) || w_data[k] !== words[k] || w_cyc[k] != e_cyc[k]) begin
                fails++;
                $display("FAIL basic_wr%0d got a=%0d d=%h c=%0d exp a=%0d d=%h c=%0d",
                         k, w_addr[k], w_data[k], w_cyc[k], k, words[k], e_cyc[k]);
            end
        end
        tests++;
        if (s_cyc.size() != 1 || s_cyc[0] != last_cyc + 1) begin
            fails++; $display("FAIL basic_start got n=%0d c=%0d exp n=1 c=%0d",
                              s_cyc.size(), (s_cyc.size() > 0) ? s_cyc[0] : -1, last_cyc + 1);
        end
        tests++;
        if (d_cyc.size() != 0) begin fails++; $display("FAIL coincident_end got %0d run_done exp 0", d_cyc.size()); end
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy_run got %b exp 1", busy); end
        repeat (50) tick();
        endProcess = 1'b1; tick(); e = cyc;
        repeat (4) tick();                     // still high while in IDLE
        endProcess = 1'b0; tick();
        tests++;
        if (d_cyc.size() != 1 || d_cyc[0] != e) begin
            fails++; $display("FAIL basic_run_done got n=%0d c=%0d exp n=1 c=%0d",
                              d_cyc.size(), (d_cyc.size() > 0) ? d_cyc[0] : -1, e);
        end
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy_idle got %b exp 0", busy); end
        clear_log();
        words = {$urandom()};
        send_stream(16'd1, 0, -1);
        repeat (3) tick();
        tests++;
        if (w_addr.size() != 1 || w_addr[0] !== '0 || w_data[0] !== words[0]) begin
            fails++; $display("FAIL reload_after_run got n=%0d exp 1 write of %h at 0", w_addr.size(), words[0]);
        end
        rst = 1'b1; release_reset();
    endtask

    task automatic test_gapped();
        clear_log();
        words = {32'h0000_0013, 32'h0010_0093};
        send_stream(16'd2, 20, -1);
        repeat (4) tick();
        tests++;
        if (w_addr.size() != 2) begin fails++; $display("FAIL gap_wr_count got %0d exp 2", w_addr.size()); end
        for (int k = 0; k < 2 && k < w_addr.size(); k++) begin
            tests++;
            if (w_addr[k] !== AW'(k) || w_data[k] !== words[k] || w_cyc[k] != e_cyc[k]) begin
                fails++;
                $display("FAIL gap_wr%0d got a=%0d d=%h c=%0d exp a=%0d d=%h c=%0d",
                         k, w_addr[k], w_data[k], w_cyc[k], k, words[k], e_cyc[k]);
            end
        end
        tests++;
        if (s_cyc.size() != 1 || s_cyc[0] != last_cyc + 1) begin
            fails++; $display("FAIL gap_start got n=%0d exp n=1 c=%0d", s_cyc.size(), last_cyc + 1);
        end
        rst = 1'b1; release_reset();
    endtask

    task automatic test_full();
        int bad;
        clear_log();
        words.delete();
        for (int k = 0; k < DEPTH; k++) words.push_back($urandom());
        send_stream(16'(DEPTH), 0, -1);
        repeat (3) tick();
        tests++;
        if (w_addr.size() != DEPTH) begin fails++; $display("FAIL full_wr_count got %0d exp %0d", w_addr.size(), DEPTH); end
        bad = 0;
        for (int k = 0; k < DEPTH && k < w_addr.size(); k++) begin
            tests++;
            if (w_addr[k] !== AW'(k) || w_data[k] !== words[k] || w_cyc[k] != e_cyc[k]) begin
                fails++; bad++;
                if (bad < 5) $display("FAIL full_wr%0d got a=%0d d=%h exp a=%0d d=%h", k, w_addr[k], w_data[k], k, words[k]);
            end
        end
        tests++;
        if (s_cyc.size() != 1 || s_cyc[0] != last_cyc + 1) begin
            fails++; $display("FAIL full_start got n=%0d exp n=1 c=%0d", s_cyc.size(), last_cyc + 1);
        end
        rst = 1'b1; release_reset();
    endtask

    task automatic test_bad_header(input logic [15:0] n);
        clear_log();
        send_byte(n[7:0]);
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL bad%0d_busy_hdr got %b exp 1", n, busy); end
        send_byte(n[15:8]);
        @(negedge clk);
        tests++;
        if (error !== 1'b1 || busy !== 1'b0) begin
            fails++; $display("FAIL bad%0d_error got err=%b busy=%b exp err=1 busy=0", n, error, busy);
        end
        tick();
        for (int i = 0; i < 12; i++) send_byte(8'($urandom()));
        endProcess = 1'b1; tick(); endProcess = 1'b0;
        repeat (3) tick();
        tests++;
        if (w_addr.size() != 0 || s_cyc.size() != 0 || d_cyc.size() != 0 || error !== 1'b1) begin
            fails++; $display("FAIL bad%0d_quiet got wr=%0d st=%0d dn=%0d err=%b exp 0 0 0 1",
                              n, w_addr.size(), s_cyc.size(), d_cyc.size(), error);
        end
        rst = 1'b1; #1;
        tests++;
        if (error !== 1'b0) begin fails++; $display("FAIL bad%0d_rst_clear got %b exp 0", n, error); end
        release_reset();
    endtask

    task automatic test_reset_mid_load();
        clear_log();
        words = {32'h0000_0013, 32'h0010_0093};
        send_stream(16'd2, 0, 8);              // header + 6 payload bytes
        rst = 1'b1; #1;
        tests += 4;
        if (im_wr_data !== 32'h0) begin fails++; $display("FAIL midrst_data got %h exp 0", im_wr_data); end
        if (im_wr_addr !== '0)    begin fails++; $display("FAIL midrst_addr got %h exp 0", im_wr_addr); end
        if (busy !== 1'b0)        begin fails++; $display("FAIL midrst_busy got %b exp 0", busy); end
        if (im_wr_en !== 1'b0 || startProcess !== 1'b0 || run_done !== 1'b0 || error !== 1'b0) begin
            fails++; $display("FAIL midrst_flags got en=%b st=%b dn=%b err=%b exp 0",
                              im_wr_en, startProcess, run_done, error);
        end
        release_reset();
        clear_log();
        send_stream(16'd2, 0, -1);
        repeat (3) tick();
        tests++;
        if (w_addr.size() != 2 || w_addr[0] !== '0 || w_data[0] !== 32'h13 || w_data[1] !== 32'h0010_0093) begin
            fails++; $display("FAIL midrst_reload got n=%0d first=%h exp n=2 first=00000013",
                              w_addr.size(), (w_data.size() > 0) ? w_data[0] : 32'hx);
        end
        rst = 1'b1; release_reset();
    endtask

    task automatic test_random();
        int n, e;
        for (int r = 0; r < 5; r++) begin
            clear_log();
            n = $urandom_range(8, 1);
            words.delete();
            for (int k = 0; k < n; k++) words.push_back($urandom());
            send_stream(16'(n), 3, -1);
            repeat ($urandom_range(20, 2)) tick();
            endProcess = 1'b1; tick(); e = cyc; endProcess = 1'b0;
            repeat (2) tick();
            tests++;
            if (w_addr.size() != n) begin fails++; $display("FAIL rnd%0d_wr_count got %0d exp %0d", r, w_addr.size(), n); end
            for (int k = 0; k < n && k < w_addr.size(); k++) begin
                tests++;
                if (w_addr[k] !== AW'(k) || w_data[k] !== words[k] || w_cyc[k] != e_cyc[k]) begin
                    fails++; $display("FAIL rnd%0d_wr%0d got a=%0d d=%h exp a=%0d d=%h", r, k, w_addr[k], w_data[k], k, words[k]);
                end
            end
            tests++;
            if (s_cyc.size() != 1 || s_cyc[0] != last_cyc + 1 || d_cyc.size() != 1 || d_cyc[0] != e || busy !== 1'b0) begin
                fails++; $display("FAIL rnd%0d_handshake got st=%0d dn=%0d busy=%b exp 1 1 0",
                                  r, s_cyc.size(), d_cyc.size(), busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gapped();
        test_full();
        test_bad_header(16'd0);
        test_bad_header(16'd513);
        test_reset_mid_load();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/im_loader.md
# im_loader

Upstream feeder for the RISC-V processor `top`: it consumes a byte stream from the board UART receiver and writes the program into instruction memory as 32-bit words. It then pulses `startProcess`, watches `endProcess`, and reports completion. It sits between the UART RX block and the processor's IM write port and start/end handshake. It replaces manual start stimulus in board bring-up.

## Interface
- `IM_MEM_DEPTH`, 512: instruction-memory depth in words. `AW = $clog2(IM_MEM_DEPTH)`.
- `DATA_WIDTH`, 32: instruction word width. Fixed at 4 bytes.

Ports:
- `clk`  in  1: system clock, single clock domain.
- `rst`  in  1: reset, asynchronous and active-high.
- `rx_data`  in  8: received byte.
- `rx_valid`  in  1: one-cycle strobe; `rx_data` is valid this cycle. There is no backpressure, and every strobe must be consumed.
- `im_wr_en`  out  1: IM write strobe.
- `im_wr_addr`  out  AW: IM word address.
- `im_wr_data`  out  32: IM write data.
- `startProcess`  out  1: one-cycle start pulse to the processor.
- `endProcess`  in  1: processor finished (level or pulse).
- `busy`  out  1: high in every state except IDLE and ERR.
- `run_done`  out  1: one-cycle pulse when `endProcess` is seen.
- `error`  out  1: sticky bad-header flag.

## Operation
- Stream format:
  - Byte 0 and byte 1 carry the word count N, little-endian, 16 bits.
  - The next N×4 bytes are the instruction words, each little-endian (first byte goes to `[7:0]`).
  - Word k is written to address k.
- FSM states: IDLE, CNT_HI, LOAD, START, RUN, ERR.
- IDLE:
  - On `rx_valid`: latch the low count byte and go to CNT_HI.
- CNT_HI:
  - On `rx_valid`: form N.
  - If N==0 or N>IM_MEM_DEPTH, go to ERR.
  - Otherwise clear the byte index (2-bit) and word counter, then go to LOAD.
- LOAD:
  - Each `rx_valid` shifts the byte into the assembly register and increments the byte index.
  - On the 4th byte (index 3), issue a write of the assembled word at the current word counter, increment the counter, and wrap the index to 0.
  - After the write of word N-1, go to START.
- START: assert `startProcess` for exactly one cycle, then go to RUN.
- RUN:
  - On `endProcess`==1, pulse `run_done` and return to IDLE.
  - `rx_valid` is ignored.
- ERR:
  - Hold `error`=1 and ignore all input until `rst`.
- The write outputs are registered in a stage independent of the FSM, so LOAD keeps accepting bytes on back-to-back cycles with no drop.
- `rx_valid` in START is ignored.
- Word counter width is AW+1, so N==IM_MEM_DEPTH does not overflow.

## Timing
- Reset (async assert, released synchronously by the system):
  - `im_wr_en`=0, `im_wr_addr`=0, `im_wr_data`=0.
  - `startProcess`=0, `busy`=0, `run_done`=0, `error`=0.
  - State is IDLE.
- Write latency: 4th byte sampled at edge t → `im_wr_en`=1 with address and data valid for exactly the cycle after t.
- `im_wr_addr` and `im_wr_data` hold their last values when `im_wr_en`=0.
- Start latency: last byte sampled at edge t → final `im_wr_en` in cycle t+1, `startProcess` high in cycle t+2 only.
- `endProcess` is first sampled in the cycle after `startProcess`. An `endProcess` coincident with `startProcess` is ignored.
- `run_done` rises in the cycle after `endProcess` is sampled high and lasts one cycle. The FSM is in IDLE from that same cycle.
- `endProcess` still high in IDLE has no effect.
- `busy` is registered:
  - Goes high in the cycle after the first count byte.
  - Goes low together with `run_done`.
- `error` rises in the cycle after the second count byte when the header is bad.
- Reset mid-LOAD or mid-RUN:
  - All outputs return to their reset values immediately (async).
  - Any pending write is discarded.
  - The partial word is lost.

## Test plan
- Load N=2 with bytes `02 00 13 00 00 00 93 00 10 00`, `rx_valid` every cycle:
  - Write addr0 data `0x00000013`, then addr1 data `0x00100093`.
  - `startProcess` is a single pulse 2 cycles after the last byte.
- Same stream with `rx_valid` strobes gapped by random 0–20 cycles: identical writes, one `startProcess`, no extra `im_wr_en`.
- N=IM_MEM_DEPTH (512):
  - 512 writes, addresses 0..511 in order.
  - Then start. No wrap to address 0 mid-load.
- Header N=0, and separately N=513:
  - `error`=1 in the cycle after the 2nd byte.
  - No `im_wr_en`, no `startProcess` ever.
  - `rst` clears `error`.
- After start, drive `endProcess` 50 cycles later (also once coincident with `startProcess`):
  - `run_done` pulses exactly once, 1 cycle after the valid `endProcess`.
  - `busy` drops. A new header is then accepted.
- Assert `rst` after 6 payload bytes of N=2:
  - Outputs return to reset values asynchronously.
  - A full reload afterwards writes addr0 first with correct data.
